// File: rtl/matrix_loader.sv
`default_nettype none
// ============================================================================
// Module   : matrix_loader
// Purpose  : Producer side of the packed NxN matrix interface. Assembles a
//            serial element stream (valid/ready) into operand A, then operand
//            B, and presents both packed buses with mat_valid until accepted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_data    in   [DW-1:0] stream element
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts an element this cycle (registered)
//   abort      in   synchronous abort of the current load
//   a_out      out  [N*N*DW-1:0] packed A, [0][0] in MSBs, row-major
//   b_out      out  [N*N*DW-1:0] packed B, same packing as a_out
//   mat_valid  out  a_out/b_out hold a complete, new pair
//   mat_ready  in   consumer accepts the pair
//   phase      out  [1:0] 0 = LOAD_A, 1 = LOAD_B, 2 = HOLD
// ----------------------------------------------------------------------------
// Configuration
//   MATRIX_LOADER_COLMAJOR_B_EN : when defined, B elements arrive in
//   column-major order (k-th element lands at row k%N, col k/N). A ordering
//   and output packing are unaffected.
// ============================================================================
module matrix_loader #(
  parameter int DW = 8,
  parameter int N  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                abort,
  output logic [N*N*DW-1:0]   a_out,
  output logic [N*N*DW-1:0]   b_out,
  output logic                mat_valid,
  input  logic                mat_ready,
  output logic [1:0]          phase
);

  localparam int NN = N * N;
  localparam int PW = NN * DW;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int OW = (PW > 1) ? $clog2(PW) : 1;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [PW-1:0]   work_a;
  logic [PW-1:0]   work_b;
  logic [PW-1:0]   a_next;
  logic [PW-1:0]   b_next;
  logic [OW-1:0]   a_off;
  logic [OW-1:0]   b_off;
  logic            xfer;
  logic            last;

  // Slot index within B for the k-th received B element.
  function automatic int b_slot(input int k);
`ifdef MATRIX_LOADER_COLMAJOR_B_EN
    return (k % N) * N + (k / N);
`else
    return k;
`endif
  endfunction

  assign xfer  = in_valid & in_ready;
  assign last  = (idx == IW'(NN - 1));
  assign phase = state;

  // Working registers with the current element merged in. The B version is
  // also what gets copied to b_out on the completing edge, so the final
  // element appears in the output on the same edge that accepts it.
  always_comb begin
    a_off  = OW'((NN - 1 - int'(idx)) * DW);
    b_off  = OW'((NN - 1 - b_slot(int'(idx))) * DW);
    a_next = work_a;
    a_next[a_off +: DW] = in_data;
    b_next = work_b;
    b_next[b_off +: DW] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LOAD_A;
      idx       <= '0;
      work_a    <= '0;
      work_b    <= '0;
      a_out     <= '0;
      b_out     <= '0;
      mat_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (abort) begin
      // Abort wins over any simultaneous transfer or acceptance; the data
      // registers are left untouched so the last good pair stays visible.
      state     <= S_LOAD_A;
      idx       <= '0;
      mat_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_LOAD_A: begin
          if (xfer) begin
            work_a <= a_next;
            if (last) begin
              idx   <= '0;
              state <= S_LOAD_B;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        S_LOAD_B: begin
          if (xfer) begin
            work_b <= b_next;
            if (last) begin
              a_out     <= work_a;
              b_out     <= b_next;
              mat_valid <= 1'b1;
              idx       <= '0;
              state     <= S_HOLD;
              in_ready  <= 1'b0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        S_HOLD: begin
          if (mat_ready) begin
            mat_valid <= 1'b0;
            state     <= S_LOAD_A;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= S_LOAD_A;
          idx       <= '0;
          mat_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
